// File: rtl/i2s_pkg.sv
// Shared defaults and the stereo frame type for the I2S transmit path.
package i2s_pkg;

    localparam int unsigned I2S_DATA_W     = 16;
    localparam int unsigned I2S_SLOT_W     = 32;
    localparam int unsigned I2S_SCLK_DIV   = 8;
    localparam int unsigned I2S_FIFO_DEPTH = 4;

    // Left sample occupies the upper half when packed.
    typedef struct packed {
        logic [I2S_DATA_W-1:0] l;
        logic [I2S_DATA_W-1:0] r;
    } stereo_frame_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of packed stereo frames; reset drops contents by clearing the pointers.
module sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(stereo_frame_t),
    parameter int unsigned DEPTH = I2S_FIFO_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_FULL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_level = r_level;

endmodule

// File: rtl/i2s_stream_tx.sv
// I2S master transmitter: valid/ready frame FIFO, sclk/ws generation and MSB-delayed serialiser.
// Define I2S_TX_HOLD_LAST_EN to resend the last popped frame on underrun instead of silence.
module i2s_stream_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W     = I2S_DATA_W,
    parameter int unsigned SLOT_W     = I2S_SLOT_W,
    parameter int unsigned SCLK_DIV   = I2S_SCLK_DIV,
    parameter int unsigned FIFO_DEPTH = I2S_FIFO_DEPTH
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data_l,
    input  logic [DATA_W-1:0]           s_data_r,
    output logic                        sclk,
    output logic                        ws,
    output logic                        sd_tx,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned HALF       = SCLK_DIV / 2;
    localparam int unsigned FRAME_BITS = 2 * SLOT_W;
    localparam int unsigned DIV_W      = $clog2(SCLK_DIV);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned FW         = 2 * DATA_W;

    logic [DIV_W-1:0]      r_div_cnt;
    logic [DIV_W-1:0]      w_div_d;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [BIT_W-1:0]      w_bit_d;
    logic                  r_sclk;
    logic                  r_ws;
    logic                  r_sd;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_image;
    logic [FW-1:0]         w_fifo_dout;
    logic [FW-1:0]         w_frame;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_div_wrap;
    logic                  w_load;
    logic                  w_pop;

    sample_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (s_valid),
        .i_data  ({s_data_l, s_data_r}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign s_ready    = !w_full;
    assign w_div_wrap = (r_div_cnt == DIV_W'(SCLK_DIV - 1));
    assign w_load     = w_div_wrap && (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
    // Emptiness is sampled before any same-cycle push, so a push on the load cycle waits a frame.
    assign w_pop      = w_load && !w_empty;
    assign underrun   = w_load && w_empty;
    assign w_div_d    = w_div_wrap ? '0 : r_div_cnt + 1'b1;
    assign w_bit_d    = (r_bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : r_bit_cnt + 1'b1;

`ifdef I2S_TX_HOLD_LAST_EN
    logic [FW-1:0] r_last;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_fifo_dout;
        end
    end

    assign w_frame = w_pop ? w_fifo_dout : r_last;
`else
    assign w_frame = w_pop ? w_fifo_dout : '0;
`endif

    // Slot bit 0 is the I2S one-bit delay; samples follow MSB first, remaining slot bits stay 0.
    always_comb begin
        w_image = '0;
        w_image[FRAME_BITS-2 -: DATA_W] = w_frame[FW-1 -: DATA_W];
        w_image[SLOT_W-2 -: DATA_W]     = w_frame[DATA_W-1:0];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_ws      <= 1'b0;
            r_sd      <= 1'b0;
            r_shift   <= '0;
        end else begin
            r_div_cnt <= w_div_d;
            r_sclk    <= (w_div_d >= DIV_W'(HALF));
            if (w_div_wrap) begin
                r_bit_cnt <= w_bit_d;
                r_ws      <= (w_bit_d >= BIT_W'(SLOT_W));
                if (w_load) begin
                    r_shift <= w_image;
                    r_sd    <= w_image[FRAME_BITS-1];
                end else begin
                    r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                    r_sd    <= r_shift[FRAME_BITS-2];
                end
            end
        end
    end

    assign sclk  = r_sclk;
    assign ws    = r_ws;
    assign sd_tx = r_sd;

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Randomised scoreboard bench for i2s_stream_tx: a queue-based frame model predicts handshake,
// level and underrun per cycle; a serial monitor decodes sclk/ws/sd_tx frames and compares.
module tb_i2s_stream_tx;

    localparam int DW        = 16;
    localparam int SW        = 32;
    localparam int DIV       = 8;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 2 * SW * DIV;
`ifdef I2S_TX_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk_in   = 1'b0;
    logic          rst_in   = 1'b1;
    logic          s_valid  = 1'b0;
    logic [DW-1:0] s_data_l = '0;
    logic [DW-1:0] s_data_r = '0;
    logic          s_ready;
    logic          sclk;
    logic          ws;
    logic          sd_tx;
    logic          underrun;
    logic [2:0]    fifo_level;

    i2s_stream_tx #(
        .DATA_W     (DW),
        .SLOT_W     (SW),
        .SCLK_DIV   (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data_l   (s_data_l),
        .s_data_r   (s_data_r),
        .sclk       (sclk),
        .ws         (ws),
        .sd_tx      (sd_tx),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: frames accepted, frames expected on the wire, cycle index since release.
    logic [31:0] m_fifo[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_last;
    int          m_cyc;
    logic        m_load;
    logic        m_ready;

    always @(negedge clk_in) begin
        if (rst_in) begin
            m_cyc  = 0;
            m_last = '0;
            m_fifo.delete();
            exp_q.delete();
        end else begin
            if (m_cyc == 0) exp_q.push_back(32'h0);
            m_load  = (m_cyc % FRAME_CYC) == FRAME_CYC - 1;
            m_ready = m_fifo.size() < DEPTH;
            check("s_ready", 64'(s_ready), 64'(m_ready));
            check("fifo_level", 64'(fifo_level), 64'(m_fifo.size()));
            check("underrun", 64'(underrun), 64'(m_load && m_fifo.size() == 0));
            if (m_load) begin
                if (m_fifo.size() != 0) begin
                    m_last = m_fifo.pop_front();
                    exp_q.push_back(m_last);
                end else begin
                    exp_q.push_back(HOLD ? m_last : 32'h0);
                end
            end
            if (s_valid && m_ready) m_fifo.push_back({s_data_l, s_data_r});
            m_cyc++;
        end
    end

    // Serial monitor: samples sd_tx/ws on each rising sclk, as a DAC would.
    logic        mon_prev_sclk;
    int          mon_pos;
    int          mon_cyc;
    int          mon_last_rise;
    logic [63:0] mon_bits;
    logic [31:0] mon_exp;
    logic [15:0] got_l;
    logic [15:0] got_r;
    int          pad_ones;

    always @(negedge clk_in) begin
        if (rst_in) begin
            mon_prev_sclk = 1'b0;
            mon_pos       = 0;
            mon_cyc       = 0;
            mon_last_rise = -1;
            mon_bits      = '0;
        end else begin
            if (sclk && !mon_prev_sclk) begin
                if (mon_last_rise >= 0) check("sclk_period", 64'(mon_cyc - mon_last_rise), 64'(DIV));
                mon_last_rise = mon_cyc;
                check("ws", 64'(ws), 64'(mon_pos >= SW));
                mon_bits[mon_pos] = sd_tx;
                mon_pos++;
                if (mon_pos == 2 * SW) begin
                    got_l    = '0;
                    got_r    = '0;
                    pad_ones = 0;
                    for (int p = 0; p < 2 * SW; p++) begin
                        if (p >= 1 && p <= DW) got_l[DW-p] = mon_bits[p];
                        else if (p >= SW + 1 && p <= SW + DW) got_r[SW+DW-p] = mon_bits[p];
                        else pad_ones += int'(mon_bits[p]);
                    end
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL frame_queue: got frame %0h want none at %0t",
                                 {got_l, got_r}, $time);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("frame_data", 64'({got_l, got_r}), 64'(mon_exp));
                        check("frame_pad", 64'(pad_ones), 64'(0));
                    end
                    mon_pos  = 0;
                    mon_bits = '0;
                end
            end
            mon_prev_sclk = sclk;
            mon_cyc++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst_in  = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int waited;
        waited   = 0;
        s_valid  = 1'b1;
        s_data_l = l;
        s_data_r = r;
        forever begin
            @(negedge clk_in);
            if (s_ready) break;
            waited++;
            if (waited > 3000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: got s_ready 0 want 1 within 3000 cycles at %0t", $time);
                break;
            end
        end
        @(posedge clk_in);
        #1;
        s_valid = 1'b0;
    endtask

    initial begin
        int waited;
        // Idle stream: silence, underrun at 511 and every 512.
        do_reset();
        idle(1100);

        // Single frame pushed early lands in the second frame.
        do_reset();
        idle(10);
        send(16'hA5A5, 16'h0F0F);
        idle(1200);

        // Overfill: fifth frame stalls until the first pop.
        do_reset();
        for (int i = 0; i < 4; i++) send(16'(16'h1000 + i), 16'(16'h2000 + i));
        check("t3_level_full", 64'(fifo_level), 64'(4));
        check("t3_ready_low", 64'(s_ready), 64'(0));
        send(16'h1004, 16'h2004);
        idle(6 * FRAME_CYC);

        // Reset in the middle of a right slot.
        do_reset();
        for (int i = 0; i < 3; i++) send(16'(16'h8001 << i), 16'(16'h7FFE >> i));
        idle(FRAME_CYC);
        waited = 0;
        while (!ws && waited < 2000) begin
            idle(1);
            waited++;
        end
        check("t4_ws_found", 64'(ws), 64'(1));
        idle(40);
        rst_in = 1'b1;
        #1;
        check("t4_rst_sclk", 64'(sclk), 64'(0));
        check("t4_rst_ws", 64'(ws), 64'(0));
        check("t4_rst_sd", 64'(sd_tx), 64'(0));
        check("t4_rst_level", 64'(fifo_level), 64'(0));
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("t4_ready_after", 64'(s_ready), 64'(1));

        // Push into the empty FIFO exactly on the load edge.
        idle(FRAME_CYC - 1);
        send(16'h1234, 16'h5678);
        check("t5_level", 64'(fifo_level), 64'(1));
        idle(2 * FRAME_CYC + 100);

        // Random traffic with bursts and starvation gaps.
        for (int i = 0; i < 30; i++) begin
            send(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(600, 1200));
            else idle($urandom_range(0, 300));
        end
        idle(3 * FRAME_CYC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
